pe_alu_xbar: RTL and testbench
==============================

PE_ALU_XBAR -- requirements
Module: pe_alu_xbar

Interface
REQ-001 SIZE, default 32, datapath width in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 config_en  input  1  high: shift the configuration chain this cycle.
REQ-005 config_in  input  1  serial configuration data in.
REQ-006 config_out  output  1  serial configuration data out, equal to cfg[12].
REQ-007 in0, in1  input  SIZE  data operands.
REQ-008 out0  output  SIZE  block result.

Function
REQ-009 Configuration SHALL be held in a 13-bit register cfg with these fields: op=cfg[3:0], outsel=cfg[4], xs0=cfg[6:5], xs1=cfg[8:7], xs2=cfg[10:9], xs3=cfg[12:11].
REQ-010 When config_en=1, each edge SHALL shift cfg: cfg[0]<=config_in, cfg[i]<=cfg[i-1]; 13 shifts load a word MSB-first.
REQ-011 The 4x4 crossbar SHALL route sources {0:in0, 1:in1, 2:alu_q, 3:dly_q} combinationally: x0 by xs0, x1 by xs1, x2 by xs2, x3 by xs3.
REQ-012 ALU operands SHALL be a=x0, b=x1, c=x3; the delay register SHALL take dly_q<=x2 each enabled cycle.
REQ-013 Each edge with config_en=0, alu_q SHALL take f(op,a,b,c); ops: 0 ADD, 1 SUB a-b, 2 MUL (low SIZE bits), 3 AND, 4 OR, 5 XOR, 6 SHL a by b[4:0], 7 SHR logical, 8 ASHR, 9 EQ, 10 LTU, 11 LTS, 12 SEL (c[0]?a:b), 13 PASS a, 14 MIN signed, 15 HOLD (alu_q unchanged).
REQ-014 Compare ops (9-11) SHALL return 1 or 0 zero-extended to SIZE; arithmetic wraps modulo 2^SIZE with no carry or overflow output.
REQ-015 out0 SHALL be combinational: outsel=0 gives alu_q, outsel=1 gives dly_q.
REQ-016 Latency SHALL be one cycle from in0/in1 to out0 through either the ALU or the delay path.
REQ-017 While config_en=1, alu_q and dly_q SHALL hold their values; reconfiguration takes effect on the first cycle after config_en falls.
REQ-018 Feedback through sources 2/3 SHALL use the registered values only, so no combinational loop is possible.

Reset
REQ-019 reset=0 at an edge SHALL clear cfg, alu_q and dly_q to 0, so out0=0 and config_out=0; this overrides config_en.
REQ-020 Reset asserted during a partial configuration shift SHALL discard the partial word; a full 13-bit reload is required afterwards.
REQ-021 After reset the all-zero configuration SHALL compute ADD(in0,in0) into alu_q.

Configuration
REQ-022 With macro PE_ALU_MUL_EN defined, op 2 SHALL produce the low SIZE bits of a*b.
REQ-023 Without PE_ALU_MUL_EN, no multiplier SHALL be built and op 2 SHALL return 0.

Verification
REQ-024 Shift in cfg=0x080 (ADD, x0=in0, x1=in1); in0=5, in1=7 -> out0=12 on the next cycle.
REQ-025 Set op=1 (SUB, cfg=0x081); in0=3, in1=5 -> out0=0xFFFFFFFE.
REQ-026 Accumulate with cfg=0x0C0 (ADD, x0=alu_q, x1=in1): in1=1 for 4 cycles after reset -> out0 steps 1, 2, 3, 4.
REQ-027 Delay path with outsel=1, xs2=1 (cfg=0x210): in1=0xA5 -> out0=0xA5 one cycle later; alu_q is unaffected.
REQ-028 Chain: shift 13 bits 1010101010101 then 13 more zeros -> config_out replays 1010101010101 in order during the second 13 cycles.
REQ-029 Assert reset mid-accumulation -> out0=0 the next cycle, cfg=0, and config_out=0.

Source files
------------

// File: rtl/pe_alu_xbar_if.sv
// Data and serial-configuration bundle for pe_alu_xbar, sized by SIZE.
// No valid/ready here: config_en alone picks shift-vs-compute, and every other cycle is a compute cycle.
interface pe_alu_xbar_if #(
    parameter int SIZE = 32
);
    logic            config_en;
    logic            config_in;
    logic            config_out;
    logic [SIZE-1:0] in0;
    logic [SIZE-1:0] in1;
    logic [SIZE-1:0] out0;

    modport master (
        output config_en, config_in, in0, in1,
        input  config_out, out0
    );

    modport slave (
        input  config_en, config_in, in0, in1,
        output config_out, out0
    );
endinterface

// File: rtl/pe_alu_xbar.sv
// Processing element: serially configured 4x4 crossbar feeding a 16-op ALU and a delay register.
// Optional macro PE_ALU_MUL_EN builds the multiplier for op 2; without it op 2 returns 0.
module pe_alu_xbar #(
    parameter int SIZE = 32
) (
    input  logic              clk,
    input  logic              reset,
    pe_alu_xbar_if.slave      bus
);
    logic [12:0]     r_cfg;
    logic [SIZE-1:0] r_alu_q;
    logic [SIZE-1:0] r_dly_q;

    logic [3:0]      w_op;
    logic            w_outsel;
    logic [SIZE-1:0] w_x [4];
    logic [SIZE-1:0] w_alu_f;

    assign w_op     = r_cfg[3:0];
    assign w_outsel = r_cfg[4];

    // Sources 2/3 are the registered ALU and delay values, so feedback never closes a comb loop.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_x[i] = '0;
            case (r_cfg[5+2*i +: 2])
                2'd0:    w_x[i] = bus.in0;
                2'd1:    w_x[i] = bus.in1;
                2'd2:    w_x[i] = r_alu_q;
                default: w_x[i] = r_dly_q;
            endcase
        end
    end

    always_comb begin
        w_alu_f = '0;
        case (w_op)
            4'd0:  w_alu_f = w_x[0] + w_x[1];
            4'd1:  w_alu_f = w_x[0] - w_x[1];
`ifdef PE_ALU_MUL_EN
            4'd2:  w_alu_f = w_x[0] * w_x[1];
`else
            4'd2:  w_alu_f = '0;
`endif
            4'd3:  w_alu_f = w_x[0] & w_x[1];
            4'd4:  w_alu_f = w_x[0] | w_x[1];
            4'd5:  w_alu_f = w_x[0] ^ w_x[1];
            4'd6:  w_alu_f = w_x[0] << w_x[1][4:0];
            4'd7:  w_alu_f = w_x[0] >> w_x[1][4:0];
            4'd8:  w_alu_f = $signed(w_x[0]) >>> w_x[1][4:0];
            4'd9:  w_alu_f = {{(SIZE-1){1'b0}}, (w_x[0] == w_x[1])};
            4'd10: w_alu_f = {{(SIZE-1){1'b0}}, (w_x[0] < w_x[1])};
            4'd11: w_alu_f = {{(SIZE-1){1'b0}}, ($signed(w_x[0]) < $signed(w_x[1]))};
            4'd12: w_alu_f = w_x[3][0] ? w_x[0] : w_x[1];
            4'd13: w_alu_f = w_x[0];
            4'd14: w_alu_f = ($signed(w_x[0]) < $signed(w_x[1])) ? w_x[0] : w_x[1];
            default: w_alu_f = r_alu_q;
        endcase
    end

    // Shifting the chain freezes the datapath; the new word takes effect once config_en drops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cfg   <= '0;
            r_alu_q <= '0;
            r_dly_q <= '0;
        end else if (bus.config_en) begin
            r_cfg <= {r_cfg[11:0], bus.config_in};
        end else begin
            r_alu_q <= w_alu_f;
            r_dly_q <= w_x[2];
        end
    end

    assign bus.config_out = r_cfg[12];
    assign bus.out0       = w_outsel ? r_dly_q : r_alu_q;
endmodule

// File: tb/tb_pe_alu_xbar.sv
// Self-checking bench for pe_alu_xbar: reference model feeds an expected queue, directed and random cases.
module tb_pe_alu_xbar;
    localparam int W = 32;

    logic clk;
    logic reset;
    pe_alu_xbar_if #(.SIZE(W)) bus ();

    pe_alu_xbar #(.SIZE(W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total = 0;
    int n_bad   = 0;
    logic [W:0] exp_q [$];

    logic [12:0]  m_cfg;
    logic [W-1:0] m_alu;
    logic [W-1:0] m_dly;

    task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pick(input logic [1:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
        case (sel)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return m_alu;
            default: return m_dly;
        endcase
    endfunction

    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] c);
        logic [W-1:0] r;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
`ifdef PE_ALU_MUL_EN
            4'd2:  r = a * b;
`else
            4'd2:  r = 0;
`endif
            4'd3:  r = a & b;
            4'd4:  r = a | b;
            4'd5:  r = a ^ b;
            4'd6:  r = a << b[4:0];
            4'd7:  r = a >> b[4:0];
            4'd8:  r = $signed(a) >>> b[4:0];
            4'd9:  r = (a == b) ? 1 : 0;
            4'd10: r = (a < b) ? 1 : 0;
            4'd11: r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd12: r = c[0] ? a : b;
            4'd13: r = a;
            4'd14: r = ($signed(a) < $signed(b)) ? a : b;
            default: r = m_alu;
        endcase
        return r;
    endfunction

    // Called at a falling edge: drive, advance the model, push the expectation, check at the next falling edge.
    task automatic cycle(input logic rst_n, input logic cen, input logic cin,
                         input logic [W-1:0] a, input logic [W-1:0] b, input string tag,
                         output logic [W-1:0] o, output logic co);
        logic [W-1:0] x0, x1, x2, x3;
        logic [W:0] e;
        reset         = rst_n;
        bus.config_en = cen;
        bus.config_in = cin;
        bus.in0       = a;
        bus.in1       = b;
        if (!rst_n) begin
            m_cfg = '0;
            m_alu = '0;
            m_dly = '0;
        end else if (cen) begin
            m_cfg = {m_cfg[11:0], cin};
        end else begin
            x0 = pick(m_cfg[6:5], a, b);
            x1 = pick(m_cfg[8:7], a, b);
            x2 = pick(m_cfg[10:9], a, b);
            x3 = pick(m_cfg[12:11], a, b);
            m_alu = ref_alu(m_cfg[3:0], x0, x1, x3);
            m_dly = x2;
        end
        exp_q.push_back({m_cfg[12], m_cfg[4] ? m_dly : m_alu});
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check(tag, {bus.config_out, bus.out0}, e);
        o  = bus.out0;
        co = bus.config_out;
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input string tag, output logic [W-1:0] o);
        logic co;
        cycle(1'b1, 1'b0, 1'b0, a, b, tag, o, co);
    endtask

    task automatic do_reset(output logic [W-1:0] o, output logic co);
        cycle(1'b0, 1'b0, 1'b0, $urandom, $urandom, "sb_reset", o, co);
    endtask

    task automatic load_cfg(input logic [12:0] word, output logic co);
        logic [W-1:0] o;
        for (int i = 12; i >= 0; i--)
            cycle(1'b1, 1'b1, word[i], $urandom, $urandom, "sb_shift", o, co);
    endtask

    logic [W-1:0] o;
    logic         co;
    logic         prev_co;
    logic [12:0]  pattern;
    logic [12:0]  word;

    initial begin
        reset = 1'b0;
        bus.config_en = 1'b0;
        bus.config_in = 1'b0;
        bus.in0 = '0;
        bus.in1 = '0;
        m_cfg = '0;
        m_alu = '0;
        m_dly = '0;
        @(negedge clk);

        do_reset(o, co);
        do_reset(o, co);
        check("reset_out0", {1'b0, o}, 0);
        check("reset_cfg_out", {{W{1'b0}}, co}, 0);

        run(9, 3, "sb_zero_cfg", o);
        check("zero_cfg_add", {1'b0, o}, 18);

        load_cfg(13'h080, co);
        run(5, 7, "sb_add", o);
        check("add_5_7", {1'b0, o}, 12);

        load_cfg(13'h081, co);
        run(3, 5, "sb_sub", o);
        check("sub_3_5", {1'b0, o}, {1'b0, 32'hFFFF_FFFE});

        do_reset(o, co);
        load_cfg(13'h0C0, co);
        for (int k = 1; k <= 4; k++) begin
            run($urandom, 1, "sb_acc", o);
            check("accumulate", {1'b0, o}, k);
        end
        do_reset(o, co);
        check("mid_reset_out0", {1'b0, o}, 0);
        check("mid_reset_cfg_out", {{W{1'b0}}, co}, 0);
        run(4, 77, "sb_after_reset", o);
        check("mid_reset_cfg_zero", {1'b0, o}, 8);

        load_cfg(13'h210, co);
        run($urandom, 32'hA5, "sb_delay", o);
        check("delay_path", {1'b0, o}, 32'hA5);

        do_reset(o, co);
        pattern = 13'b1010101010101;
        load_cfg(pattern, prev_co);
        for (int k = 0; k < 13; k++) begin
            check("chain_replay", {{W{1'b0}}, prev_co}, {{W{1'b0}}, pattern[12-k]});
            cycle(1'b1, 1'b1, 1'b0, $urandom, $urandom, "sb_chain", o, prev_co);
        end

        do_reset(o, co);
        for (int k = 0; k < 6; k++)
            cycle(1'b1, 1'b1, 1'b1, $urandom, $urandom, "sb_partial", o, co);
        do_reset(o, co);
        check("partial_cfg_out", {{W{1'b0}}, co}, 0);
        run(6, 1, "sb_partial_add", o);
        check("partial_discarded", {1'b0, o}, 12);

        for (int it = 0; it < 40; it++) begin
            word = 13'($urandom_range(0, 13'h1FFF));
            load_cfg(word, co);
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 1) == 1)
                    run($urandom, $urandom, "sb_random", o);
                else
                    run($urandom_range(0, 40), $urandom_range(0, 40), "sb_random_small", o);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
